// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: ALU control codes, ALUOp codes, R-type funct codes
// and the control word loaded into ID/EX when a bubble is inserted.
package mips_pkg;

    localparam logic [3:0] ALUCTL_AND = 4'd0;
    localparam logic [3:0] ALUCTL_OR  = 4'd1;
    localparam logic [3:0] ALUCTL_ADD = 4'd2;
    localparam logic [3:0] ALUCTL_NOR = 4'd3;
    localparam logic [3:0] ALUCTL_XOR = 4'd4;
    localparam logic [3:0] ALUCTL_SUB = 4'd6;
    localparam logic [3:0] ALUCTL_SLT = 4'd7;
    localparam logic [3:0] ALUCTL_DEC = 4'd8;
    localparam logic [3:0] ALUCTL_MUL = 4'd9;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_XOR   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_MUL   = 3'b111;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       illegal;
        logic [3:0] alu_ctl;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        alu_src:    1'b0,
        reg_dst:    1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        illegal:    1'b0,
        alu_ctl:    ALUCTL_ADD
    };

    // Instructions that actually consume rt as a register operand (R-type, SUB-compare, MUL, stores).
    function automatic logic needs_rt(input logic [2:0] alu_op, input logic mem_write);
        return (alu_op == ALUOP_RTYPE) | (alu_op == ALUOP_SUB) |
               (alu_op == ALUOP_MUL) | mem_write;
    endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// Combinational ALUOp/funct to 4-bit ALU control decode; flags undecodable R-type funct codes.
module alu_control_decoder
    import mips_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctl_o,
    output logic       illegal_o
);

    // Decode ALUOp directly, falling through to the funct field for R-type.
    always_comb begin
        alu_ctl_o = ALUCTL_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_ctl_o = ALUCTL_ADD;
            ALUOP_SUB: alu_ctl_o = ALUCTL_SUB;
            ALUOP_AND: alu_ctl_o = ALUCTL_AND;
            ALUOP_OR:  alu_ctl_o = ALUCTL_OR;
            ALUOP_XOR: alu_ctl_o = ALUCTL_XOR;
            ALUOP_SLT: alu_ctl_o = ALUCTL_SLT;
            ALUOP_MUL: alu_ctl_o = ALUCTL_MUL;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD, FUNCT_ADDU: alu_ctl_o = ALUCTL_ADD;
                    FUNCT_SUB, FUNCT_SUBU: alu_ctl_o = ALUCTL_SUB;
                    FUNCT_AND:             alu_ctl_o = ALUCTL_AND;
                    FUNCT_OR:              alu_ctl_o = ALUCTL_OR;
                    FUNCT_XOR:             alu_ctl_o = ALUCTL_XOR;
                    FUNCT_NOR:             alu_ctl_o = ALUCTL_NOR;
                    FUNCT_SLT:             alu_ctl_o = ALUCTL_SLT;
                    default: begin
                        alu_ctl_o = ALUCTL_ADD;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: alu_ctl_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register bank feeding the ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection and bubble insertion on stall or flush.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    input  logic [REG_AW-1:0] IdRd,
    input  logic [DATA_W-1:0] IdReadData1,
    input  logic [DATA_W-1:0] IdReadData2,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [5:0]        IdFunct,
    input  logic [2:0]        IdALUOp,
    input  logic              IdALUSrc,
    input  logic              IdRegDst,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemToReg,
    input  logic              Flush,
    input  logic              ExMemRegWrite,
    input  logic [REG_AW-1:0] ExMemRd,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic              MemWbRegWrite,
    input  logic [REG_AW-1:0] MemWbRd,
    input  logic [DATA_W-1:0] MemWbData,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        ALUControl,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_AW-1:0] ExDestReg,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExMemToReg,
    output logic              IllegalOp,
    output logic              Stall
);

    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    ex_ctrl_t          ctrl_q, ctrl_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [3:0]        dec_ctl_s;
    logic              dec_illegal_s;
    logic              stall_s;
    logic [DATA_W-1:0] fwd_rs_s, fwd_rt_s;

    alu_control_decoder u_alu_control_decoder (
        .alu_op_i  (IdALUOp),
        .funct_i   (IdFunct),
        .alu_ctl_o (dec_ctl_s),
        .illegal_o (dec_illegal_s)
    );

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        stall_s = 1'b0;
        if (ctrl_q.mem_read && (rt_q != REG_ZERO)) begin
            stall_s = (rt_q == IdRs) || ((rt_q == IdRt) && needs_rt(IdALUOp, IdMemWrite));
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next EX contents: a bubble on flush or stall, otherwise the decoded ID instruction.
    always_comb begin
        ctrl_d = EX_CTRL_BUBBLE;
        rs_d   = REG_ZERO;
        rt_d   = REG_ZERO;
        rd_d   = REG_ZERO;
        rd1_d  = DATA_ZERO;
        rd2_d  = DATA_ZERO;
        imm_d  = DATA_ZERO;
        if (Flush || stall_s) begin
            ctrl_d = EX_CTRL_BUBBLE;
        end else begin
            ctrl_d.alu_src    = IdALUSrc;
            ctrl_d.reg_dst    = IdRegDst;
            ctrl_d.reg_write  = IdRegWrite;
            ctrl_d.mem_read   = IdMemRead;
            ctrl_d.mem_write  = IdMemWrite;
            ctrl_d.mem_to_reg = IdMemToReg;
            ctrl_d.illegal    = dec_illegal_s;
            ctrl_d.alu_ctl    = dec_ctl_s;
            rs_d  = IdRs;
            rt_d  = IdRt;
            rd_d  = IdRd;
            rd1_d = IdReadData1;
            rd2_d = IdReadData2;
            imm_d = IdImm;
        end
    end

    // ID/EX register bank; reset leaves a clean bubble.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl_q <= EX_CTRL_BUBBLE;
            rs_q   <= REG_ZERO;
            rt_q   <= REG_ZERO;
            rd_q   <= REG_ZERO;
            rd1_q  <= DATA_ZERO;
            rd2_q  <= DATA_ZERO;
            imm_q  <= DATA_ZERO;
        end else begin
            ctrl_q <= ctrl_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins and $0 always reads its register value.
    always_comb begin
        fwd_rs_s = rd1_q;
        fwd_rt_s = rd2_q;
        if (ExMemRegWrite && (ExMemRd == rs_q) && (rs_q != REG_ZERO)) begin
            fwd_rs_s = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd == rs_q) && (rs_q != REG_ZERO)) begin
            fwd_rs_s = MemWbData;
        end else begin
            fwd_rs_s = rd1_q;
        end
        if (ExMemRegWrite && (ExMemRd == rt_q) && (rt_q != REG_ZERO)) begin
            fwd_rt_s = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd == rt_q) && (rt_q != REG_ZERO)) begin
            fwd_rt_s = MemWbData;
        end else begin
            fwd_rt_s = rd2_q;
        end
    end

    assign A          = fwd_rs_s;
    assign B          = ctrl_q.alu_src ? imm_q : fwd_rt_s;
    assign StoreData  = fwd_rt_s;
    assign ALUControl = ctrl_q.alu_ctl;
    assign ExDestReg  = ctrl_q.reg_dst ? rd_q : rt_q;
    assign ExRegWrite = ctrl_q.reg_write;
    assign ExMemRead  = ctrl_q.mem_read;
    assign ExMemWrite = ctrl_q.mem_write;
    assign ExMemToReg = ctrl_q.mem_to_reg;
    assign IllegalOp  = ctrl_q.illegal;
    assign Stall      = stall_s;

endmodule
